// File: rtl/cam_cfg_pkg.sv
// cam_cfg_pkg: shared state encoding and table markers for the camera configuration sequencer
package cam_cfg_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_ROM, S_DECODE, S_WRITE, S_DELAY, S_DONE, S_ERR
    } state_t;
    localparam logic [15:0] END_MARK   = 16'hFFFF;
    localparam logic [7:0]  DLY_PREFIX = 8'hFF;
    function automatic int cyc_per_ms(input int clk_hz);
        return clk_hz / 1000;
    endfunction
endpackage

// File: rtl/cam_cfg_seq_if.sv
// cam_cfg_seq_if: register-write handshake between the sequencer and the SCCB write master
interface cam_cfg_seq_if;
    logic       valid;
    logic [7:0] reg_addr;
    logic [7:0] data;
    logic       ready;
    modport master(output valid, reg_addr, data, input ready);
    modport slave(input valid, reg_addr, data, output ready);
endinterface

// File: rtl/cam_ms_timer.sv
// cam_ms_timer: millisecond delay timer; o_expired marks the last cycle of an i_ms*CPM cycle window
module cam_ms_timer #(
    parameter int CPM = 27000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_ms,
    output logic       o_expired
);
    localparam int CW = $clog2(CPM > 1 ? CPM : 2);
    localparam logic [CW-1:0] CYC_LAST = CW'(CPM - 1);
    logic [CW-1:0] cyc_q, cyc_d;
    logic [7:0] ms_q, ms_d, tgt_q, tgt_d;
    logic run_q, run_d, wrap;
    always_comb begin
        wrap      = run_q && cyc_q == CYC_LAST;
        o_expired = wrap && ms_q == tgt_q - 8'd1;
        cyc_d     = (i_load || wrap) ? '0 : cyc_q + CW'(run_q);
        ms_d      = i_load ? 8'd0 : ms_q + 8'(wrap);
        tgt_d     = i_load ? i_ms : tgt_q;
        run_d     = i_load ? i_ms != 8'd0 : run_q && !o_expired;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ms_q  <= '0;
            tgt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cyc_q <= cyc_d;
            ms_q  <= ms_d;
            tgt_q <= tgt_d;
            run_q <= run_d;
        end
    end
endmodule

// File: rtl/cam_cfg_seq.sv
// cam_cfg_seq: walks a {reg,data} table, issuing SCCB writes and executing delay/end markers
module cam_cfg_seq
    import cam_cfg_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int CLK_HZ     = 27_000_000,
    parameter int DELAY_MS   = 10,
    parameter bit SCALED_DLY = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    cam_cfg_seq_if.master     sccb,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_wr_count
);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d;
    logic [7:0] reg_q, reg_d, data_q, data_d, dly_ms;
    logic valid_q, valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic is_dly, tmr_load, tmr_exp, adv;
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        reg_d    = reg_q;
        data_d   = data_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        is_dly   = i_rom_data[15:8] == DLY_PREFIX;
        dly_ms   = SCALED_DLY ? i_rom_data[7:0] : 8'(DELAY_MS);
        tmr_load = 1'b0;
        adv      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (i_start) begin
                state_d = S_FETCH;
                addr_d  = i_base;
                cnt_d   = '0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                err_d   = 1'b0;
            end
            S_FETCH:    state_d = S_WAIT_ROM;
            S_WAIT_ROM: state_d = S_DECODE;
            S_DECODE:
                if (i_rom_data == END_MARK) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (is_dly && dly_ms != 8'd0) begin
                    tmr_load = 1'b1;
                    state_d  = S_DELAY;
                end else if (is_dly) begin
                    adv = 1'b1;
                end else begin
                    state_d = S_WRITE;
                    valid_d = 1'b1;
                    reg_d   = i_rom_data[15:8];
                    data_d  = i_rom_data[7:0];
                end
            S_WRITE: if (sccb.ready) begin
                valid_d = 1'b0;
                cnt_d   = cnt_q == ADDR_MAX ? cnt_q : cnt_q + 1'b1;
                adv     = 1'b1;
            end
            S_DELAY: adv = tmr_exp;
            default: state_d = S_IDLE;
        endcase
        // the table never wraps: stepping past the last address is a missing end marker
        if (adv) begin
            if (addr_q == ADDR_MAX) begin
                state_d = S_ERR;
                err_d   = 1'b1;
                busy_d  = 1'b0;
            end else begin
                state_d = S_FETCH;
                addr_d  = addr_q + 1'b1;
            end
        end
    end
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            reg_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    cam_ms_timer #(.CPM(cyc_per_ms(CLK_HZ))) u_tmr (
        .clk      (i_clk),
        .rst_n    (i_rstn),
        .i_load   (tmr_load),
        .i_ms     (dly_ms),
        .o_expired(tmr_exp)
    );
    assign o_rom_addr    = addr_q;
    assign o_wr_count    = cnt_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_err         = err_q;
    assign sccb.valid    = valid_q;
    assign sccb.reg_addr = reg_q;
    assign sccb.data     = data_q;
endmodule

// File: tb/tb_cam_cfg_seq.sv
// tb_cam_cfg_seq: randomized scoreboard bench for cam_cfg_seq against a table-walking reference model
module tb_cam_cfg_seq;
    localparam int A_HZ = 5000, A_CPM = 5, A_DMS = 3, B_HZ = 7000;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    logic start_a = 1'b0, start_b = 1'b0;
    logic [7:0] base_a = 8'd0, base_b = 8'd0, addr_a, addr_b, cnt_a, cnt_b;
    logic [15:0] rom_a [256];
    logic [15:0] rom_b [256];
    logic [15:0] rd_a, rd_b;
    logic busy_a, done_a, err_a, busy_b, done_b, err_b;
    cam_cfg_seq_if if_a();
    cam_cfg_seq_if if_b();
    assign if_b.ready = 1'b1;
    cam_cfg_seq #(.ADDR_W(8), .CLK_HZ(A_HZ), .DELAY_MS(A_DMS), .SCALED_DLY(1'b0)) dut_a (
        .i_clk(clk), .i_rstn(rst_n), .i_start(start_a), .i_base(base_a),
        .o_rom_addr(addr_a), .i_rom_data(rd_a), .sccb(if_a),
        .o_busy(busy_a), .o_done(done_a), .o_err(err_a), .o_wr_count(cnt_a)
    );
    cam_cfg_seq #(.ADDR_W(8), .CLK_HZ(B_HZ), .DELAY_MS(A_DMS), .SCALED_DLY(1'b1)) dut_b (
        .i_clk(clk), .i_rstn(rst_n), .i_start(start_b), .i_base(base_b),
        .o_rom_addr(addr_b), .i_rom_data(rd_b), .sccb(if_b),
        .o_busy(busy_b), .o_done(done_b), .o_err(err_b), .o_wr_count(cnt_b)
    );
    always @(posedge clk) begin
        rd_a <= rom_a[addr_a];
        rd_b <= rom_b[addr_b];
    end
    int pass_n = 0, tot_n = 0;
    logic [15:0] exp_q [$];
    int mode = 0, sc = 0, hs_b = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [7:0] preg = 8'd0, pdat = 8'd0;
    logic [15:0] hs_b_val = 16'd0;
    logic exp_done, exp_err;
    int exp_cnt, exp_cyc, exp_addr;
    task automatic chk(input string nm, input int got, input int exp);
        tot_n++;
        if (got == exp) pass_n++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask
    // monitor: ready chosen here is what the DUT sees at the next rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
            sc = 0;
            if_a.ready = 1'b0;
        end else begin
            if (pv && !pr) chk("hold", {if_a.valid, if_a.reg_addr, if_a.data}, {1'b1, preg, pdat});
            if (!if_a.valid) sc = 0;
            if_a.ready = mode == 0 ? 1'b1 : mode == 1 ? (if_a.valid && sc >= 5) :
                         mode == 2 ? ($urandom_range(2) == 0) : 1'b0;
            if (if_a.valid) sc++;
            if (if_a.valid && if_a.ready) begin
                if (exp_q.size() == 0) chk("hs_extra", exp_q.size(), 1);
                else chk("hs_data", {if_a.reg_addr, if_a.data}, exp_q.pop_front());
            end
            pv = if_a.valid;
            pr = if_a.ready;
            preg = if_a.reg_addr;
            pdat = if_a.data;
            if (if_b.valid) begin
                hs_b++;
                hs_b_val = {if_b.reg_addr, if_b.data};
            end
        end
    end
    task automatic model(input logic [7:0] base);
        int a;
        logic [15:0] e;
        exp_q.delete();
        exp_cnt = 0; exp_cyc = 0; exp_done = 1'b0; exp_err = 1'b0;
        a = base;
        while (!exp_done && !exp_err) begin
            e = rom_a[a];
            exp_cyc += 3;
            if (e == 16'hFFFF) exp_done = 1'b1;
            else begin
                if (e[15:8] == 8'hFF) exp_cyc += A_DMS * A_CPM;
                else begin
                    exp_q.push_back(e);
                    exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
                    exp_cyc += 1;
                end
                if (a == 255) exp_err = 1'b1;
                else a++;
            end
        end
        exp_addr = a;
    endtask
    task automatic run_a(input logic [7:0] base, input int md, input bit dbl);
        int cyc;
        cyc = 0;
        model(base);
        mode = md;
        @(negedge clk); start_a = 1'b1; base_a = base;
        @(negedge clk); start_a = 1'b0;
        while (busy_a && cyc < 20000) begin
            cyc++;
            if (dbl && cyc == 3) begin start_a = 1'b1; base_a = ~base; end
            else start_a = 1'b0;
            @(negedge clk);
        end
        start_a = 1'b0;
        chk("busy_bound", cyc < 20000, 1);
        chk("done", done_a, exp_done);
        chk("err", err_a, exp_err);
        chk("wr_count", cnt_a, exp_cnt);
        chk("rom_addr", addr_a, exp_addr);
        chk("writes_left", exp_q.size(), 0);
        if (md == 0) chk("busy_cycles", cyc, exp_cyc);
    endtask
    task automatic chk_reset();
        chk("rst_addr", addr_a, 0);
        chk("rst_sccb", {if_a.valid, if_a.reg_addr, if_a.data}, 0);
        chk("rst_status", {busy_a, done_a, err_a}, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_b", {addr_b, if_b.valid, busy_b, done_b, err_b, cnt_b}, 0);
    endtask
    task automatic fill_rand(input bit ends);
        int r;
        for (int i = 0; i < 256; i++) begin
            r = $urandom_range(15);
            if (ends && r == 0) rom_a[i] = 16'hFFFF;
            else if (r < 3) rom_a[i] = {8'hFF, 8'($urandom_range(254))};
            else rom_a[i] = {8'($urandom_range(254)), 8'($urandom)};
        end
    endtask
    task automatic reset_mid(input int wait_cyc, input bit wait_valid);
        exp_q.delete();
        mode = 3;
        @(negedge clk); start_a = 1'b1; base_a = 8'd0;
        @(negedge clk); start_a = 1'b0;
        for (int k = 0; k < wait_cyc && !(wait_valid && if_a.valid); k++) @(negedge clk);
        if (wait_valid) chk("valid_seen", if_a.valid, 1);
        else chk("busy_seen", busy_a, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset();
        @(negedge clk); #2 rst_n = 1'b1;
    endtask
    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) begin rom_a[i] = 16'h0; rom_b[i] = 16'h0; end
        #12 chk_reset();
        @(negedge clk); #2 rst_n = 1'b1;
        rom_a[0] = 16'h1280; rom_a[1] = 16'hFFF0; rom_a[2] = 16'h1214; rom_a[3] = 16'hFFFF;
        run_a(8'h00, 0, 1'b0);
        run_a(8'h00, 1, 1'b0);
        rom_a[8'h40] = 16'h8C02; rom_a[8'h41] = 16'hFFFF;
        run_a(8'h40, 0, 1'b1);
        run_a(8'h40, 0, 1'b0);
        rom_b[0] = 16'hFF03; rom_b[1] = 16'hFF00; rom_b[2] = 16'h1234; rom_b[3] = 16'hFFFF;
        hs_b = 0; cyc = 0;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        while (busy_b && cyc < 2000) begin cyc++; @(negedge clk); end
        chk("b_busy_cycles", cyc, 12 + 3 * (B_HZ / 1000) + 1);
        chk("b_done_err", {done_b, err_b}, 2);
        chk("b_count", cnt_b, 1);
        chk("b_writes", hs_b, 1);
        chk("b_write_val", hs_b_val, 16'h1234);
        for (int i = 0; i < 256; i++) rom_a[i] = {8'(i % 255), 8'(i)};
        run_a(8'h00, 0, 1'b0);
        fill_rand(1'b0);
        run_a(8'($urandom_range(255)), 2, 1'b0);
        for (int t = 0; t < 12; t++) begin
            fill_rand(1'b1);
            run_a(8'($urandom_range(255)), $urandom_range(2), 1'($urandom_range(1)));
        end
        rom_a[0] = 16'h5566; rom_a[1] = 16'hFFFF;
        reset_mid(20, 1'b1);
        run_a(8'h00, 0, 1'b0);
        rom_a[0] = 16'hFFF0; rom_a[1] = 16'h1234; rom_a[2] = 16'hFFFF;
        reset_mid(8, 1'b0);
        run_a(8'h00, 0, 1'b0);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
